vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port video RAM between two requesters. The display line
//  fetcher copies the next visible line into a ping-pong line buffer during
//  horizontal blanking. The pattern writer issues single-word writes through a
//  req/ack handshake. Runs in the pixel-clock domain of the sync generator and
//  consumes its HCNT/VCNT.
//  Display fetch has absolute priority; the writer gets every other free cycle.
// PARAMETERS
//  HVISIBLE   640  visible pixels per line; fetch trigger at HCNT==HVISIBLE
//  HPERIOD    800  total pixels per line
//  VVISIBLE   480  visible lines per frame
//  VPERIOD    525  total lines per frame
//  WPL        40   VRAM words per line (16 px/word)
//  ADDR_W     15   VRAM word-address width
//  DATA_W     64   VRAM data width
//  RD_LAT     1    VRAM read latency in cycles (1..4)
// PORTS
//  CLK        in   1       pixel clock (same clock as HCNT/VCNT)
//  RST        in   1       reset, asynchronous, active-high
//  HCNT       in   10      horizontal counter from sync generator
//  VCNT       in   10      vertical counter from sync generator
//  wr_req     in   1       writer request; held high until wr_ack
//  wr_addr    in   ADDR_W  writer word address; stable while wr_req=1
//  wr_data    in   DATA_W  writer data; stable while wr_req=1
//  wr_ack     out  1       1-cycle pulse; write performed this cycle
//  mem_re     out  1       VRAM read strobe
//  mem_we     out  1       VRAM write strobe
//  mem_addr   out  ADDR_W  VRAM address
//  mem_wdata  out  DATA_W  VRAM write data
//  mem_rdata  in   DATA_W  VRAM read data, valid RD_LAT cycles after mem_re
//  lb_we      out  1       line-buffer write strobe
//  lb_bank    out  1       line-buffer bank = target line bit 0
//  lb_addr    out  6       line-buffer word index 0..WPL-1
//  lb_wdata   out  DATA_W  line-buffer write data (= mem_rdata)
//  underrun   out  1       sticky flag; fetch not finished by end of line
//  underrun_clr in 1       synchronous clear of underrun
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; fetch_pend=0; read pipeline flushed.
//  - Reset mid-fetch aborts the fetch. No lb_we is issued for in-flight reads.
//  Target line: nl = (VCNT==VPERIOD-1) ? 0 : VCNT+1.
//  - Trigger = (HCNT==HVISIBLE) && (nl < VVISIBLE).
//  - Base address = nl*WPL, truncated to ADDR_W.
//  FSM states: IDLE, FETCH, WRITE. All mem_* outputs are registered.
//  - IDLE: trigger or fetch_pend -> FETCH, k=0. Otherwise wr_req -> WRITE.
//    Trigger wins over a simultaneous wr_req.
//  - FETCH: mem_re=1, mem_addr=base+k for k=0..WPL-1 on consecutive cycles.
//    First read is the cycle after the trigger edge. After k=WPL-1 -> IDLE.
//  - WRITE: exactly 1 cycle. mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data,
//    wr_ack=1. Then -> IDLE.
//    A trigger during WRITE sets fetch_pend; the fetch starts the next cycle.
//  Read return: lb_we=1, lb_addr=k, lb_bank=nl[0] exactly RD_LAT cycles after
//  read k. A delay pipeline tags each read. Returns may overlap a later WRITE.
//  mem_re and mem_we are never both 1 in the same cycle.
//  Writer starves only during FETCH. Worst-case wr_ack latency is WPL+2 cycles.
//  Underrun: FSM still in FETCH at HCNT==HPERIOD-1
//  - Set underrun (sticky) and abort the fetch -> IDLE.
//  - underrun_clr and a set in the same cycle: set wins.
//  No fetch is triggered for lines VVISIBLE-1..VPERIOD-2.
//  - VCNT==VPERIOD-1 fetches line 0 into bank 0.
// TESTING
//  1 Reset, VCNT=9, HCNT steps to 640 -> 40 reads addr 400..439, first read
//    at cycle after HCNT=640; lb_we idx 0..39 bank 0, RD_LAT later.
//  2 wr_req (addr 0x123, data 0xAB) raised in IDLE -> next cycle mem_we=1,
//    addr 0x123, wr_ack=1 for exactly 1 cycle.
//  3 wr_req rising in the same cycle as the trigger -> 40 reads first;
//    wr_ack on the cycle after the last read.
//  4 VCNT=524 trigger -> addr 0..39, bank 0. VCNT=479 -> no reads issued.
//  5 Assert RST at read k=20 -> all outputs 0 immediately, no further lb_we.
//    After release, the next trigger performs a full fetch.
//  6 WPL=200 with HVISIBLE=640 -> underrun=1 at HCNT=799, FSM IDLE.
//    underrun_clr -> underrun=0 the next cycle.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display line fetch during hblank has absolute priority,
// pattern-writer single-word writes fill the remaining free cycles.
module vram_arbiter #(
    parameter int HVISIBLE = 640,
    parameter int HPERIOD  = 800,
    parameter int VVISIBLE = 480,
    parameter int VPERIOD  = 525,
    parameter int WPL      = 40,
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 64,
    parameter int RD_LAT   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [9:0]        HCNT,
    input  logic [9:0]        VCNT,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [5:0]        lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam int KW = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [ADDR_W-1:0] base_q;
    logic              bank_q;
    logic              fetch_pend;

    logic [9:0]        nl;
    logic              trigger;
    logic              eol;
    logic [ADDR_W-1:0] base;

    // Read-return tag pipeline: one stage per cycle of VRAM read latency
    logic              pv [RD_LAT];
    logic [KW-1:0]     pi [RD_LAT];
    logic              pb [RD_LAT];

    assign nl      = (VCNT == 10'(VPERIOD - 1)) ? 10'd0 : VCNT + 10'd1;
    assign trigger = (HCNT == 10'(HVISIBLE)) && (nl < 10'(VVISIBLE));
    assign eol     = (HCNT == 10'(HPERIOD - 1));
    assign base    = ADDR_W'(int'(nl) * WPL);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            k          <= '0;
            base_q     <= '0;
            bank_q     <= 1'b0;
            fetch_pend <= 1'b0;
            wr_ack     <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            underrun   <= 1'b0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            wr_ack <= 1'b0;
            if (underrun_clr) begin
                underrun <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (trigger) begin
                        base_q     <= base;
                        bank_q     <= nl[0];
                        mem_re     <= 1'b1;
                        mem_addr   <= base;
                        k          <= '0;
                        fetch_pend <= 1'b0;
                        state      <= FETCH;
                    end else if (fetch_pend) begin
                        mem_re     <= 1'b1;
                        mem_addr   <= base_q;
                        k          <= '0;
                        fetch_pend <= 1'b0;
                        state      <= FETCH;
                    end else if (wr_req) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= wr_data;
                        wr_ack    <= 1'b1;
                        state     <= WRITE;
                    end
                end
                FETCH: begin
                    if (eol) begin
                        // Line ended before all words were read: abandon the line
                        underrun <= 1'b1;
                        state    <= IDLE;
                    end else if (k == KW'(WPL - 1)) begin
                        // Hand the bus straight to a waiting writer after the last read
                        if (wr_req) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_addr;
                            mem_wdata <= wr_data;
                            wr_ack    <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        k        <= k + KW'(1);
                        mem_re   <= 1'b1;
                        mem_addr <= base_q + ADDR_W'(k) + ADDR_W'(1);
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    if (trigger) begin
                        base_q     <= base;
                        bank_q     <= nl[0];
                        fetch_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pi[i] <= '0;
                pb[i] <= 1'b0;
            end
        end else begin
            pv[0] <= mem_re;
            pi[0] <= k;
            pb[0] <= bank_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pi[i] <= pi[i-1];
                pb[i] <= pb[i-1];
            end
        end
    end

    assign lb_we    = pv[RD_LAT-1];
    assign lb_addr  = 6'(pi[RD_LAT-1]);
    assign lb_bank  = pb[RD_LAT-1];
    assign lb_wdata = lb_we ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: line fetch, writes, priority, vertical wrap,
// reset abort and underrun (second instance with an oversized line).
module tb_vram_arbiter;

    localparam int WPL    = 40;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 64;
    localparam logic [63:0] RD_PAT = 64'hA5A5_0000_0000_0000;

    logic              CLK = 1'b0;
    logic              RST, RST2;
    logic [9:0]        HCNT, VCNT;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack, mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              lb_we, lb_bank;
    logic [5:0]        lb_addr;
    logic [DATA_W-1:0] lb_wdata;
    logic              underrun, underrun_clr;

    logic              u_wr_ack, u_mem_re, u_mem_we;
    logic [ADDR_W-1:0] u_mem_addr;
    logic [DATA_W-1:0] u_mem_wdata;
    logic [DATA_W-1:0] u_mem_rdata = '0;
    logic              u_lb_we, u_lb_bank;
    logic [5:0]        u_lb_addr;
    logic [DATA_W-1:0] u_lb_wdata;
    logic              u_underrun;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // One-cycle-latency VRAM whose data encodes the address read
    always @(posedge CLK) mem_rdata <= RD_PAT | 64'(mem_addr);

    vram_arbiter dut (
        .CLK(CLK), .RST(RST), .HCNT(HCNT), .VCNT(VCNT),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    vram_arbiter #(.WPL(200)) dut_long (
        .CLK(CLK), .RST(RST2), .HCNT(HCNT), .VCNT(VCNT),
        .wr_req(1'b0), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(u_wr_ack),
        .mem_re(u_mem_re), .mem_we(u_mem_we), .mem_addr(u_mem_addr),
        .mem_wdata(u_mem_wdata), .mem_rdata(u_mem_rdata),
        .lb_we(u_lb_we), .lb_bank(u_lb_bank), .lb_addr(u_lb_addr), .lb_wdata(u_lb_wdata),
        .underrun(u_underrun), .underrun_clr(underrun_clr)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expects read k=0 visible now; walks the whole fetch and its line-buffer returns
    task automatic fetch_check(input int base, input logic bank);
        for (int k = 0; k < WPL; k++) begin
            chk("fetch_re", 64'(mem_re), 64'd1);
            chk("fetch_addr", 64'(mem_addr), 64'(base + k));
            chk("fetch_no_we", 64'(mem_we), 64'd0);
            chk("fetch_no_ack", 64'(wr_ack), 64'd0);
            if (k > 0) begin
                chk("lb_we", 64'(lb_we), 64'd1);
                chk("lb_addr", 64'(lb_addr), 64'(k - 1));
                chk("lb_bank", 64'(lb_bank), 64'(bank));
                chk("lb_wdata", lb_wdata, RD_PAT | 64'(base + k - 1));
            end else begin
                chk("lb_quiet_first", 64'(lb_we), 64'd0);
            end
            HCNT = HCNT + 10'd1;
            step();
        end
        chk("fetch_done_re", 64'(mem_re), 64'd0);
        chk("lb_last_we", 64'(lb_we), 64'd1);
        chk("lb_last_addr", 64'(lb_addr), 64'(WPL - 1));
        chk("lb_last_wdata", lb_wdata, RD_PAT | 64'(base + WPL - 1));
    endtask

    initial begin
        RST = 1'b1; RST2 = 1'b1;
        HCNT = 10'd0; VCNT = 10'd0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        underrun_clr = 1'b0;
        step(); step();

        chk("rst_re", 64'(mem_re), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_ack", 64'(wr_ack), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_lb_we", 64'(lb_we), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);

        // Line 10 fetch, bank 0, addresses 400..439
        RST = 1'b0;
        VCNT = 10'd9; HCNT = 10'd638;
        step();
        HCNT = 10'd639;
        step();
        chk("pre_trigger_re", 64'(mem_re), 64'd0);
        HCNT = 10'd640;
        step();
        fetch_check(400, 1'b0);
        step();
        chk("lb_quiet_after", 64'(lb_we), 64'd0);

        // Single write from IDLE
        wr_addr = 15'h123; wr_data = 64'hAB; wr_req = 1'b1;
        step();
        chk("wr_we", 64'(mem_we), 64'd1);
        chk("wr_addr", 64'(mem_addr), 64'h123);
        chk("wr_data", mem_wdata, 64'hAB);
        chk("wr_ack", 64'(wr_ack), 64'd1);
        chk("wr_no_re", 64'(mem_re), 64'd0);
        wr_req = 1'b0;
        step();
        chk("wr_ack_pulse", 64'(wr_ack), 64'd0);
        chk("wr_we_pulse", 64'(mem_we), 64'd0);

        // Trigger and write request together: fetch first, ack right after last read
        VCNT = 10'd20; HCNT = 10'd639;
        step();
        HCNT = 10'd640;
        wr_addr = 15'h2AA; wr_data = 64'h55; wr_req = 1'b1;
        step();
        fetch_check(840, 1'b1);
        chk("late_ack", 64'(wr_ack), 64'd1);
        chk("late_we", 64'(mem_we), 64'd1);
        chk("late_addr", 64'(mem_addr), 64'h2AA);
        chk("late_data", mem_wdata, 64'h55);
        wr_req = 1'b0;
        step();
        chk("late_ack_pulse", 64'(wr_ack), 64'd0);

        // Last line wraps to line 0
        VCNT = 10'd524; HCNT = 10'd639;
        step();
        HCNT = 10'd640;
        step();
        fetch_check(0, 1'b0);

        // Line 480 is not visible: no fetch
        VCNT = 10'd479; HCNT = 10'd640;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("blank_no_re", 64'(mem_re), 64'd0);
            HCNT = HCNT + 10'd1;
        end

        // Reset during read k=20 aborts the fetch
        VCNT = 10'd100; HCNT = 10'd640;
        step();
        for (int k = 0; k < 20; k++) begin
            HCNT = HCNT + 10'd1;
            step();
        end
        chk("pre_abort_addr", 64'(mem_addr), 64'd4060);
        RST = 1'b1;
        #1;
        chk("abort_re", 64'(mem_re), 64'd0);
        chk("abort_addr", 64'(mem_addr), 64'd0);
        chk("abort_lb_we", 64'(lb_we), 64'd0);
        chk("abort_lb_wdata", lb_wdata, 64'd0);
        step();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_abort_lb_we", 64'(lb_we), 64'd0);
            chk("post_abort_re", 64'(mem_re), 64'd0);
        end
        HCNT = 10'd640;
        step();
        fetch_check(4040, 1'b1);

        // 200-word line cannot finish in hblank
        RST2 = 1'b0;
        VCNT = 10'd9; HCNT = 10'd639;
        step();
        HCNT = 10'd640;
        step();
        chk("long_fetch_re", 64'(u_mem_re), 64'd1);
        for (int h = 641; h <= 799; h++) begin
            HCNT = 10'(h);
            if (h == 799) chk("underrun_before", 64'(u_underrun), 64'd0);
            step();
        end
        chk("underrun_set", 64'(u_underrun), 64'd1);
        chk("underrun_idle", 64'(u_mem_re), 64'd0);
        chk("short_no_underrun", 64'(underrun), 64'd0);
        HCNT = 10'd0; VCNT = 10'd10;
        step();
        chk("underrun_sticky", 64'(u_underrun), 64'd1);
        chk("underrun_stays_idle", 64'(u_mem_re), 64'd0);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("underrun_cleared", 64'(u_underrun), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
